// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command at a time travels over AW/W/B or
// AR/R. A watchdog aborts a stalled bus transfer and reports it on the response port.
`timescale 1ns/1ps
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int WD_WIDTH   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_ON      = (TIMEOUT_CYCLES > 0);
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_ON ? WD_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [WD_WIDTH-1:0] WD_MAX  = '1;
  localparam logic [WD_WIDTH-1:0] WD_ONE  = WD_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_RSP
  } state_e;

  state_e                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic [WD_WIDTH-1:0]     wdog_q, wdog_d;

  logic b_hs, r_hs, aw_done, w_done, bus_busy;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    wdog_d        = wdog_q;

    b_hs     = BVALID && bready_q;
    r_hs     = RVALID && rready_q;
    aw_done  = !awvalid_q || AWREADY;
    w_done   = !wvalid_q || WREADY;
    bus_busy = state_q inside {S_WADDR, S_WRESP, S_RADDR, S_RDATA};

    if (WD_ON && bus_busy && (wdog_q != WD_MAX)) begin
      wdog_d = wdog_q + WD_ONE;
    end

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          wdog_d      = '0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WADDR;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = S_RADDR;
          end
        end
      end

      S_WADDR: begin
        // AW and W complete independently; whichever finishes first simply waits.
        if (awvalid_q && AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end

      S_WRESP: begin
        if (b_hs) begin
          bready_d      = 1'b0;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RSP;
        end
      end

      S_RADDR: begin
        if (arvalid_q && ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end

      S_RDATA: begin
        if (r_hs) begin
          rready_d      = 1'b0;
          rsp_rdata_d   = RDATA;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RSP;
        end
      end

      S_RSP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          cmd_ready_d   = 1'b1;
          state_d       = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Watchdog abort; a B/R handshake in the same cycle takes priority.
    if (WD_ON && bus_busy && (wdog_q == WD_LAST) && !b_hs && !r_hs) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
      rsp_valid_d   = 1'b1;
      state_d       = S_RSP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: all registers here are plain control/data flops (no memory arrays), so each gets a reset value.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      wdog_q        <= wdog_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign AWADDR      = awaddr_q;
  assign AWVALID     = awvalid_q;
  assign WDATA       = wdata_q;
  assign WSTRB       = wstrb_q;
  assign WVALID      = wvalid_q;
  assign BREADY      = bready_q;
  assign ARADDR      = araddr_q;
  assign ARVALID     = arvalid_q;
  assign RREADY      = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a 4x32b AXI-lite register-file slave with stall knobs,
// a directed command driver feeding an expected-response queue, and a response monitor.
`timescale 1ns/1ps
module tb_axi_lite_master;

  logic        ACLK    = 1'b0;
  logic        ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
  logic [3:0]  cmd_addr  = '0,   cmd_wstrb = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [3:0]  AWADDR, ARADDR, WSTRB;
  logic [31:0] WDATA;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
  logic [31:0] RDATA = '0;

  axi_lite_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
  );

  int tests_run = 0, tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // ---------------- slave model (acts on the falling edge) ----------------
  logic [31:0] regs [4];
  logic        aw_got, w_got, ar_got, b_fire, r_fire;
  logic [3:0]  s_awaddr, s_araddr, s_wstrb, aw_first;
  logic [31:0] s_wdata;
  int          aw_wait, b_cnt = 0, aw_stall = 0, wv_cnt = 0, awaddr_bad = 0;
  int          aw_delay = 0;
  logic        b_block = 1'b0, ar_block = 1'b0;

  always @(negedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < 4; i++) regs[i] = '0;
      aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0; aw_wait = 0;
      AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RDATA = '0;
      s_awaddr = '0; s_araddr = '0; s_wstrb = '0; s_wdata = '0; aw_first = '0;
    end else begin
      if (WVALID) wv_cnt++;
      // B: commit the write when both halves arrived, then hold BVALID until accepted
      if (b_fire) begin
        BVALID = 0; b_fire = 0;
      end else begin
        if (!BVALID && aw_got && w_got && !b_block) begin
          for (int i = 0; i < 4; i++)
            if (s_wstrb[i]) regs[s_awaddr[3:2]][8*i +: 8] = s_wdata[8*i +: 8];
          BVALID = 1; aw_got = 0; w_got = 0;
        end
        if (BVALID && BREADY) begin b_fire = 1; b_cnt++; end
      end
      if (r_fire) begin
        RVALID = 0; r_fire = 0;
      end else begin
        if (!RVALID && ar_got) begin
          RDATA = regs[s_araddr[3:2]]; RVALID = 1; ar_got = 0;
        end
        if (RVALID && RREADY) r_fire = 1;
      end
      if (AWVALID && !aw_got) begin
        if (aw_wait == 0) aw_first = AWADDR;
        else if (AWADDR != aw_first) awaddr_bad++;
        if (aw_wait >= aw_delay) begin
          AWREADY = 1; aw_got = 1; s_awaddr = AWADDR; aw_wait = 0;
        end else begin
          AWREADY = 0; aw_wait++; aw_stall++;
        end
      end else AWREADY = 0;
      if (WVALID && !w_got) begin
        WREADY = 1; w_got = 1; s_wdata = WDATA; s_wstrb = WSTRB;
      end else WREADY = 0;
      if (ARREADY) begin
        ARREADY = 0; ar_got = 1;
      end else if (ARVALID && !ar_block && !ar_got && !RVALID) begin
        ARREADY = 1; s_araddr = ARADDR;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [31:0] rdata; logic timeout; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic busy = 1'b0;
  int   ready_viol = 0;

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      busy = 1'b0;
    end else begin
      if (busy && cmd_ready) ready_viol++;
      if (rsp_valid && rsp_ready) begin
        busy = 1'b0;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, mon_e.rdata);
          check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, mon_e.timeout});
        end
      end
      if (cmd_valid && cmd_ready) busy = 1'b1;
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic wr, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_to);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 100) begin @(posedge ACLK); #1; n++; end
    if (!cmd_ready) begin
      check("cmd_accept_bound", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge ACLK); #1;
    exp_q.push_back('{rdata: exp_rd, timeout: exp_to});
    cmd_valid = 1'b0;
    if (wr) check("awvalid_wvalid_n1", {30'b0, AWVALID, WVALID}, 32'd3);
    else    check("arvalid_n1", {31'b0, ARVALID}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 200) begin @(posedge ACLK); #1; n++; end
    check("drain_bound", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] tbl [4];
  int n, cnt, held, b0, st0, wv0, bad0;

  initial begin
    tbl[0] = 32'h0000_1000; tbl[1] = 32'h1111_2222; tbl[2] = 32'h3333_4444; tbl[3] = 32'h5555_6666;
    #1;
    check("reset_ctrl", {24'b0, cmd_ready, rsp_valid, rsp_timeout, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 32'd0);
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    check("cmd_ready_before_edge", {31'b0, cmd_ready}, 32'd0);
    @(posedge ACLK); #1;
    check("cmd_ready_after_reset", {31'b0, cmd_ready}, 32'd1);

    // 1: basic write then read
    b0 = b_cnt; st0 = aw_stall;
    issue(1'b1, 4'h4, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    wait_done();
    check("t1_b_count", b_cnt - b0, 32'd1);
    check("t1_aw_stall", aw_stall - st0, 32'd0);
    issue(1'b0, 4'h4, '0, '0, 32'hDEAD_BEEF, 1'b0);
    wait_done();

    // 2: partial-strobe merge, response held while rsp_ready is low
    issue(1'b1, 4'h8, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    issue(1'b1, 4'h8, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0);
    wait_done();
    rsp_ready = 1'b0;
    issue(1'b0, 4'h8, '0, '0, 32'h11BB_33DD, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge ACLK); #1; n++; end
    held = 0;
    repeat (3) begin @(posedge ACLK); #1; if (rsp_valid) held++; end
    check("t2_rsp_hold", held, 32'd3);
    rsp_ready = 1'b1;
    wait_done();

    // 3: AWREADY stalled 3 cycles while W completes at once
    aw_delay = 3; b0 = b_cnt; st0 = aw_stall; wv0 = wv_cnt; bad0 = awaddr_bad;
    issue(1'b1, 4'hC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    wait_done();
    aw_delay = 0;
    check("t3_aw_stall", aw_stall - st0, 32'd3);
    check("t3_wvalid_cycles", wv_cnt - wv0, 32'd1);
    check("t3_awaddr_stable", awaddr_bad - bad0, 32'd0);
    check("t3_b_count", b_cnt - b0, 32'd1);
    issue(1'b0, 4'hC, '0, '0, 32'hCAFE_F00D, 1'b0);
    wait_done();

    // 4: back-to-back writes then reads
    for (int i = 0; i < 4; i++) issue(1'b1, 4'(i * 4), tbl[i], 4'hF, 32'h0, 1'b0);
    wait_done();
    for (int i = 0; i < 4; i++) issue(1'b0, 4'(i * 4), '0, '0, tbl[i], 1'b0);
    wait_done();

    // 5: ARREADY never arrives -> watchdog abort after 16 cycles
    ar_block = 1'b1;
    issue(1'b0, 4'h4, '0, '0, 32'h0, 1'b1);
    cnt = ARVALID ? 1 : 0;
    n = 0;
    while (ARVALID && n < 40) begin
      @(posedge ACLK); #1; n++;
      if (ARVALID) cnt++;
    end
    check("t5_arvalid_cycles", cnt, 32'd16);
    check("t5_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    wait_done();
    ar_block = 1'b0;
    issue(1'b0, 4'h4, '0, '0, tbl[1], 1'b0);
    wait_done();

    // 6: async reset in WRESP
    rsp_ready = 1'b0; b_block = 1'b1;
    issue(1'b1, 4'h0, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b0);
    n = 0;
    while (!BREADY && n < 20) begin @(posedge ACLK); #1; n++; end
    check("t6_in_wresp", {31'b0, BREADY}, 32'd1);
    @(posedge ACLK); #2;
    ARESETn = 1'b0;
    #1;
    check("t6_rst_ctrl", {24'b0, cmd_ready, rsp_valid, rsp_timeout, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 32'd0);
    check("t6_rst_rdata", rsp_rdata, 32'd0);
    check("t6_rst_wdata", WDATA, 32'd0);
    check("t6_rst_addr", {20'b0, AWADDR, ARADDR, WSTRB}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1; b_block = 1'b0; rsp_ready = 1'b1;
    @(posedge ACLK); #1;
    check("t6_cmd_ready_next_edge", {31'b0, cmd_ready}, 32'd1);
    issue(1'b0, 4'h0, '0, '0, 32'h0, 1'b0);
    wait_done();

    check("cmd_ready_low_while_busy", ready_viol, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
